// File: rtl/input_manager.sv
// input_manager: UART (8N1) byte receiver feeding a byte FIFO, followed by a
// big-endian 32-bit word assembler with a valid/ready handshake.
//
// Ports:
//   CLK         - system clock, all logic on the rising edge
//   INITIALIZE  - synchronous active-high reset
//   UART_RX     - asynchronous serial input, idle high
//   word_ready  - consumer accepts the presented word this cycle
//   word_valid  - word holds four complete bytes (registered)
//   word        - assembled word, first byte received in [31:24] (registered)
//   fifo_count  - bytes buffered in the FIFO, not counting the holding register
//   overrun     - sticky: a received byte was dropped because the FIFO was full
//   frame_err   - sticky: a received byte was dropped because its stop bit was 0
module input_manager #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 512
) (
   input  logic                         CLK,
   input  logic                         INITIALIZE,
   input  logic                         UART_RX,
   input  logic                         word_ready,
   output logic                         word_valid,
   output logic [31:0]                  word,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overrun,
   output logic                         frame_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Synchronizer
   logic sync1_q, rx_s_q;
   logic rx_s;

   // Receiver
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          push;

   // FIFO
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full, push_ok, pop;
   logic [7:0]    rd_data;

   // Word assembly and flags
   logic [31:0] hold_q, hold_d;
   logic [2:0]  nb_q, nb_d;
   logic        word_valid_q, word_valid_d;
   logic        overrun_q, overrun_d;
   logic        frame_err_q, frame_err_d;

   assign rx_s = rx_s_q;

   // Receiver FSM: half-bit delay to the middle of the start bit, then one
   // full bit period between samples.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      push        = 1'b0;
      frame_err_d = frame_err_q;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d = ST_START;
               cnt_d   = HALF_LOAD;
            end
         end
         ST_START: begin
            if (cnt_q == '0) begin
               if (!rx_s) begin
                  state_d   = ST_DATA;
                  cnt_d     = BIT_LOAD;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = ST_IDLE;  // glitch: start bit gone by mid-bit
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s, shift_q[7:1]};  // LSB arrives first
               cnt_d   = BIT_LOAD;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               if (rx_s) begin
                  push = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FIFO bookkeeping and word assembly
   assign rd_data = mem[rd_ptr_q];

   always_comb begin
      // Fullness is judged on the registered count, so a same-cycle pop does
      // not make room for the incoming byte.
      full      = (count_q == DEPTH_C);
      push_ok   = push && !full;
      overrun_d = overrun_q || (push && full);
      pop       = (nb_q != 3'd4) && (count_q != '0);

      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase

      hold_d = hold_q;
      nb_d   = nb_q;
      if (pop) begin
         hold_d = {hold_q[23:0], rd_data};
         nb_d   = nb_q + 3'd1;
      end else if (word_valid_q && word_ready) begin
         nb_d = 3'd0;
      end
      word_valid_d = (nb_d == 3'd4);
   end

   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= shift_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (INITIALIZE) begin
         sync1_q      <= 1'b1;
         rx_s_q       <= 1'b1;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         hold_q       <= '0;
         nb_q         <= '0;
         word_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         sync1_q      <= UART_RX;
         rx_s_q       <= sync1_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         hold_q       <= hold_d;
         nb_q         <= nb_d;
         word_valid_q <= word_valid_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign word_valid = word_valid_q;
   assign word       = hold_q;
   assign fifo_count = count_q;
   assign overrun    = overrun_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_input_manager.sv
// tb_input_manager: directed bench for input_manager with a short bit period
// and a small FIFO. A vector table drives byte-by-byte expectations; separate
// sequences cover back-pressure, overrun, glitches and mid-frame reset.
module tb_input_manager;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        init = 1'b0;
   logic        rx = 1'b1;
   logic        ready = 1'b0;
   logic        valid;
   logic [31:0] word;
   logic [3:0]  count;
   logic        ovr;
   logic        ferr;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        consume;   // pulse word_ready before sending
      logic [7:0]  data;
      logic        stop;
      logic        exp_valid;
      logic [31:0] exp_word;
      logic [3:0]  exp_count;
      logic        exp_ovr;
      logic        exp_ferr;
   } vec_t;

   vec_t vecs[6];

   input_manager #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .CLK        (clk),
      .INITIALIZE (init),
      .UART_RX    (rx),
      .word_ready (ready),
      .word_valid (valid),
      .word       (word),
      .fifo_count (count),
      .overrun    (ovr),
      .frame_err  (ferr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      init = 1'b1;
      rx = 1'b1;
      ready = 1'b0;
      tick();
      tick();
      init = 1'b0;
      tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) tick();
      end
      rx = stop;
      repeat (CPB) tick();
      rx = 1'b1;
      repeat (2 * CPB) tick();
   endtask

   task automatic pulse_ready();
      ready = 1'b1;
      tick();
      ready = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " valid"}, 32'(valid), 32'd0);
      check({tag, " word"}, word, 32'd0);
      check({tag, " count"}, 32'(count), 32'd0);
      check({tag, " overrun"}, 32'(ovr), 32'd0);
      check({tag, " frame_err"}, 32'(ferr), 32'd0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 8'hAB, 1'b1, 1'b0, 32'h000000AB, 4'd0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'hCD, 1'b1, 1'b0, 32'h0000ABCD, 4'd0, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 8'hEF, 1'b1, 1'b0, 32'h00ABCDEF, 4'd0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'h01, 1'b1, 1'b1, 32'hABCDEF01, 4'd0, 1'b0, 1'b0};
      // Bad stop bit: byte dropped, word untouched, flag sticks afterwards.
      vecs[4] = '{1'b1, 8'hA5, 1'b0, 1'b0, 32'hABCDEF01, 4'd0, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 8'h5A, 1'b1, 1'b0, 32'hCDEF015A, 4'd0, 1'b0, 1'b1};

      // Reset state
      do_reset();
      check_idle_outputs("reset");

      // Table-driven byte sequence
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].consume) pulse_ready();
         send_byte(vecs[i].data, vecs[i].stop);
         check($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d word", i), word, vecs[i].exp_word);
         check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
         check($sformatf("vec%0d overrun", i), 32'(ovr), 32'(vecs[i].exp_ovr));
         check($sformatf("vec%0d frame_err", i), 32'(ferr), 32'(vecs[i].exp_ferr));
         if (i == 2) check("vec2 nb", 32'(dut.nb_q), 32'd3);
      end

      // Back-pressure: word held while not accepted
      do_reset();
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1);
      send_byte(8'h78, 1'b1);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("hold%0d valid", i), 32'(valid), 32'd1);
         check($sformatf("hold%0d word", i), word, 32'h12345678);
         tick();
      end
      pulse_ready();
      check("accept valid", 32'(valid), 32'd0);

      // Overrun: 13 bytes with no consumer
      do_reset();
      for (int i = 0; i < 13; i++) send_byte(8'(i), 1'b1);
      check("ovr word", word, 32'h00010203);
      check("ovr valid", 32'(valid), 32'd1);
      check("ovr count", 32'(count), 32'd8);
      check("ovr flag", 32'(ovr), 32'd1);
      pulse_ready();
      repeat (8) tick();
      check("drain1 word", word, 32'h04050607);
      check("drain1 count", 32'(count), 32'd4);
      check("drain1 valid", 32'(valid), 32'd1);
      pulse_ready();
      repeat (8) tick();
      check("drain2 word", word, 32'h08090A0B);
      check("drain2 count", 32'(count), 32'd0);
      check("drain2 overrun", 32'(ovr), 32'd1);
      pulse_ready();
      repeat (8) tick();
      check("drain3 valid", 32'(valid), 32'd0);
      check("drain3 count", 32'(count), 32'd0);

      // One-cycle glitch on the line
      do_reset();
      rx = 1'b0;
      tick();
      rx = 1'b1;
      repeat (10) tick();
      check_idle_outputs("glitch");
      check("glitch state", 32'(dut.state_q), 32'd0);
      check("glitch nb", 32'(dut.nb_q), 32'd0);

      // Reset during bit 4 of 0x3C, then a full frame
      do_reset();
      rx = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 4; i++) begin
         rx = (i >= 2) ? 1'b1 : 1'b0;
         repeat (CPB) tick();
      end
      rx = 1'b1;
      tick();
      tick();
      init = 1'b1;
      tick();
      tick();
      init = 1'b0;
      repeat (40) tick();
      check_idle_outputs("midreset");
      check("midreset state", 32'(dut.state_q), 32'd0);
      send_byte(8'h3C, 1'b1);
      check("after word", word, 32'h0000003C);
      check("after valid", 32'(valid), 32'd0);
      check("after count", 32'(count), 32'd0);
      check("after nb", 32'(dut.nb_q), 32'd1);
      check("after frame_err", 32'(ferr), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/input_manager.md
INPUT_MANAGER -- requirements
Module: input_manager

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 512, meaning byte FIFO capacity (power of two).
REQ-003 SHALL have port CLK, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port INITIALIZE, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port UART_RX, input, 1, asynchronous serial line, 8N1, idle high.
REQ-006 SHALL have port word_ready, input, 1, consumer accepts the word this cycle.
REQ-007 SHALL have port word_valid, output, 1, high when word holds 4 complete bytes.
REQ-008 SHALL have port word, output, 32, assembled word, big-endian (first byte received in [31:24]).
REQ-009 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, bytes currently buffered in the FIFO, excluding the holding register.
REQ-010 SHALL have port overrun, output, 1, sticky flag: a byte was dropped because the FIFO was full.
REQ-011 SHALL have port frame_err, output, 1, sticky flag: a byte was dropped because its stop bit sampled 0.

Function
REQ-012 SHALL pass UART_RX through a 2-flop synchronizer; all receiver logic uses the synchronized value rx_s.
REQ-013 SHALL implement a receiver FSM with states IDLE, START, DATA and STOP, plus a bit-period counter and a bit index.
REQ-014 SHALL in IDLE move to START on rx_s == 0 and load the counter for CLKS_PER_BIT/2 cycles.
REQ-015 SHALL in START, at counter expiry, go to DATA if rx_s == 0; otherwise return to IDLE (glitch reject, no byte produced).
REQ-016 SHALL in DATA sample rx_s every CLKS_PER_BIT cycles, 8 samples, LSB first, then go to STOP.
REQ-017 SHALL in STOP sample after CLKS_PER_BIT cycles and return to IDLE in the same cycle: rx_s == 1 pushes the byte; rx_s == 0 sets frame_err and drops the byte.
REQ-018 SHALL drop a pushed byte and set overrun when fifo_count == FIFO_DEPTH (evaluated on the registered count), even if a pop occurs in the same cycle.
REQ-019 SHALL use read/write pointers that wrap modulo FIFO_DEPTH; fifo_count +1 on push only, -1 on pop only, unchanged on push and pop together.
REQ-020 SHALL keep a 32-bit holding register and a byte counter nb (0..4); when nb < 4 and fifo_count > 0, pop one byte per cycle: hold <= {hold[23:0], byte}, nb <= nb + 1.
REQ-021 SHALL drive word_valid = (nb == 4) and word = hold, both registered.
REQ-022 SHALL hold word stable while word_valid && !word_ready.
REQ-023 SHALL on word_valid && word_ready set nb to 0 with no pop that cycle; word_valid is low the next cycle.
REQ-024 SHALL meet this latency: a byte pushed at edge t is visible in fifo_count at t+1, popped at edge t+1, and in hold after t+1; if it completes a word, word_valid is high in the cycle after edge t+1.
REQ-025 SHALL clear overrun and frame_err only on INITIALIZE.

Reset
REQ-026 SHALL on INITIALIZE: synchronizer flops and rx_s to 1, FSM to IDLE, counters/pointers/fifo_count/nb to 0, word to 0, word_valid/overrun/frame_err to 0.
REQ-027 SHALL on INITIALIZE mid-frame abort the partial byte with no push; reception restarts at the next falling edge after release.
REQ-028 SHALL lose FIFO contents on reset; RAM contents need not be cleared.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8 for sim)
REQ-029 SHALL cover: send 0x12,0x34,0x56,0x78 with word_ready=0 -> word_valid=1, word=0x12345678, held stable 10 cycles; word_ready pulse -> word_valid=0 next cycle.
REQ-030 SHALL cover: send 0xAB,0xCD,0xEF only -> word_valid stays 0, fifo_count returns to 0, nb=3; send 0x01 -> word=0xABCDEF01.
REQ-031 SHALL cover: send 0xA5 with stop bit 0 -> frame_err=1, fifo_count=0, no word progress; the following good byte is received normally.
REQ-032 SHALL cover: word_ready=0, send 13 bytes 0x00..0x0C -> word=0x00010203, fifo_count=8, overrun=1, 0x0C lost; subsequent drain yields 0x04050607 then 0x08090A0B.
REQ-033 SHALL cover: UART_RX low for 1 cycle only -> no byte, FSM back in IDLE, flags 0.
REQ-034 SHALL cover: INITIALIZE asserted during bit 4 of 0x3C -> no push, all outputs 0; next full frame 0x3C accepted.
